// File: rtl/score_keeper_pkg.sv
// Shared constants for the scoring stage and the display path.
// Contents:
//   SCORE_DIGITS / SCORE_W : BCD digit count and score width
//   SCORE_MAX_DEF          : default score saturation value (BCD)
//   PTS_W, PTSn_DEF        : width and default values of points per clear
package score_keeper_pkg;

    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_W      = 4 * SCORE_DIGITS;

    localparam logic [SCORE_W-1:0] SCORE_MAX_DEF = 16'h9999;

    localparam int PTS_W    = 4;
    localparam int PTS1_DEF = 1;
    localparam int PTS2_DEF = 3;
    localparam int PTS3_DEF = 5;
    localparam int PTS4_DEF = 8;

endpackage

// File: rtl/score_keeper_bcd_inc4.sv
// Combinational 4-digit BCD increment.
// Ports:
//   value_i : BCD value, digit 0 in [3:0]
//   value_o : value_i + 1 in BCD (wraps 9999 -> 0000)
//   carry_o : high when value_i was 9999
module bcd_inc4
    import score_keeper_pkg::*;
(
    input  logic [SCORE_W-1:0] value_i,
    output logic [SCORE_W-1:0] value_o,
    output logic               carry_o
);

    logic carry;

    // Ripple the +1 from digit 0 upward; a 9 becomes 0 and passes the carry on.
    always_comb begin
        carry   = 1'b1;
        value_o = value_i;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (carry) begin
                if (value_i[4*d +: 4] == 4'd9) begin
                    value_o[4*d +: 4] = 4'd0;
                end else begin
                    value_o[4*d +: 4] = value_i[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        carry_o = carry;
    end

endmodule

// File: rtl/score_keeper.sv
// Scoring stage: turns line-clear events into a BCD score, one point per cycle.
// Ports:
//   clk, reset_n             : clock, synchronous active-low reset
//   game_start               : pulse, clears score/pending (hi_score kept)
//   game_over                : level, freezes scoring and flushes pending
//   clear_valid, clear_lines : line-clear event and line count
//   score, hi_score          : current / best score, 4 BCD digits
//   score_inc                : one cycle per point added to score
//   busy                     : pending points still draining
//   new_record               : pulse when hi_score is updated
// Events are accepted on any cycle; there is no back-pressure.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int                 PTS1      = PTS1_DEF,
    parameter int                 PTS2      = PTS2_DEF,
    parameter int                 PTS3      = PTS3_DEF,
    parameter int                 PTS4      = PTS4_DEF,
    parameter int                 PEND_W    = 6,
    parameter logic [SCORE_W-1:0] SCORE_MAX = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               game_start,
    input  logic               game_over,
    input  logic               clear_valid,
    input  logic [2:0]         clear_lines,
    output logic [SCORE_W-1:0] score,
    output logic               score_inc,
    output logic [SCORE_W-1:0] hi_score,
    output logic               busy,
    output logic               new_record
);

    localparam int SUM_W = PEND_W + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic               score_inc_q, score_inc_d;
    logic               new_record_q, new_record_d;
    logic               game_over_q;

    logic [PTS_W-1:0]   pts;
    logic [SCORE_W-1:0] score_plus1;
    logic               inc_carry;
    logic               accept;
    logic               drain;
    logic [SUM_W-1:0]   pend_sum;

    bcd_inc4 u_inc (
        .value_i (score_q),
        .value_o (score_plus1),
        .carry_o (inc_carry)
    );

    always_comb begin
        case (clear_lines)
            3'd1:    pts = PTS_W'(PTS1);
            3'd2:    pts = PTS_W'(PTS2);
            3'd3:    pts = PTS_W'(PTS3);
            3'd4:    pts = PTS_W'(PTS4);
            default: pts = '0;
        endcase
    end

    assign accept = clear_valid && !game_over && !game_start;
    // The carry guard keeps the score from wrapping even if SCORE_MAX is
    // configured past 9999.
    assign drain  = (pending_q != '0) && !game_over && (score_q != SCORE_MAX)
                    && !inc_carry;

    // Accept and drain may coincide; pending never underflows because drain
    // requires pending != 0. Widened by one bit so the saturation is visible.
    assign pend_sum = {1'b0, pending_q} + SUM_W'(accept ? pts : '0)
                      - SUM_W'(drain);

    always_comb begin
        score_d      = score_q;
        pending_d    = pending_q;
        score_inc_d  = 1'b0;
        hi_d         = hi_q;
        new_record_d = 1'b0;

        if (game_start) begin
            score_d   = '0;
            pending_d = '0;
        end else begin
            if (game_over || (score_q == SCORE_MAX)) begin
                pending_d = '0;
            end else if (pend_sum > {1'b0, PEND_MAX}) begin
                pending_d = PEND_MAX;
            end else begin
                pending_d = pend_sum[PEND_W-1:0];
            end
            if (drain) begin
                score_d     = score_plus1;
                score_inc_d = 1'b1;
            end
        end

        // Raw unsigned compare is order-preserving for packed BCD.
        if (game_over && !game_over_q && (score_q > hi_q)) begin
            hi_d         = score_q;
            new_record_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            score_q      <= '0;
            hi_q         <= '0;
            pending_q    <= '0;
            score_inc_q  <= 1'b0;
            new_record_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            score_q      <= score_d;
            hi_q         <= hi_d;
            pending_q    <= pending_d;
            score_inc_q  <= score_inc_d;
            new_record_q <= new_record_d;
            game_over_q  <= game_over;
        end
    end

    assign score      = score_q;
    assign hi_score   = hi_q;
    assign score_inc  = score_inc_q;
    assign new_record = new_record_q;
    assign busy       = (pending_q != '0);

endmodule
